// File: rtl/grid_stream_encoder.sv
// grid_stream_encoder: frames a latched grid plus a buffered move list into a valid/ready byte stream.
// Define STREAM_CHECKSUM_EN to append an XOR trailer byte after the move section.
module grid_stream_encoder #(
   parameter int         WIDTH       = 8,
   parameter int         HEIGHT      = 8,
   parameter int         DATA_WIDTH  = 8,
   parameter int         MOVE_WIDTH  = 16,
   parameter int         MAX_MOVES   = 220,
   parameter logic [7:0] GRID_HEADER = 8'b11_01_01_01,
   parameter logic [7:0] MOVE_HEADER = 8'b11_10_10_10
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                grid_iv,
   input  logic [HEIGHT*WIDTH*DATA_WIDTH-1:0]  grid_id,
   input  logic                                move_iv,
   input  logic [MOVE_WIDTH-1:0]               move_id,
   input  logic                                start,
   input  logic                                spi_ready,
   output logic                                spi_ov,
   output logic [DATA_WIDTH-1:0]               spi_od,
   output logic                                busy,
   output logic                                done,
   output logic                                overflow
);
   localparam int CELLS      = HEIGHT * WIDTH;
   localparam int GRID_BITS  = CELLS * DATA_WIDTH;
   localparam int CELL_W     = (CELLS > 1) ? $clog2(CELLS) : 1;
   localparam int MOVE_BYTES = MOVE_WIDTH / 8;
   localparam int BIDX_W     = (MOVE_BYTES > 1) ? $clog2(MOVE_BYTES) : 1;
   localparam int CNT_W      = 8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      GRID_HDR = 3'd1,
      GRID     = 3'd2,
      MOVE_HDR = 3'd3,
      COUNT    = 3'd4,
      MOVES    = 3'd5,
      CKSUM    = 3'd6
   } state_t;

   state_t                  state_q, state_d;
   logic [GRID_BITS-1:0]    grid_q, grid_d;
   logic [CNT_W-1:0]        move_cnt_q, move_cnt_d;
   logic                    overflow_q, overflow_d;
   logic [CELL_W-1:0]       cell_q, cell_d;
   logic [CNT_W-1:0]        mi_q, mi_d;
   logic [BIDX_W-1:0]       bi_q, bi_d;
   logic                    spi_ov_q, spi_ov_d;
   logic [DATA_WIDTH-1:0]   spi_od_q, spi_od_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [MOVE_WIDTH-1:0]   buf_q [MAX_MOVES];
   logic                    push_s;
   logic                    xfer_s;
   logic                    tail_s;
   logic                    end_s;
`ifdef STREAM_CHECKSUM_EN
   logic [DATA_WIDTH-1:0]   cksum_q, cksum_d;
`endif

   function automatic logic [DATA_WIDTH-1:0] cell_byte(input logic [GRID_BITS-1:0] g,
                                                       input logic [CELL_W-1:0] idx);
      return g[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
   endfunction

   // Most significant byte of a move goes out first.
   function automatic logic [DATA_WIDTH-1:0] move_byte(input logic [MOVE_WIDTH-1:0] w,
                                                       input logic [BIDX_W-1:0] b);
      logic [MOVE_WIDTH-1:0] sh;
      sh = w >> ((MOVE_BYTES - 1 - int'(b)) * 8);
      return DATA_WIDTH'(sh[7:0]);
   endfunction

   assign xfer_s = spi_ov_q & spi_ready;

   // Next-state, output byte and index counter selection
   always_comb begin
      state_d    = state_q;
      grid_d     = grid_q;
      move_cnt_d = move_cnt_q;
      overflow_d = overflow_q;
      cell_d     = cell_q;
      mi_d       = mi_q;
      bi_d       = bi_q;
      spi_ov_d   = spi_ov_q;
      spi_od_d   = spi_od_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      push_s     = 1'b0;
      tail_s     = 1'b0;
      end_s      = 1'b0;
      case (state_q)
         IDLE: begin
            if (grid_iv) grid_d = grid_id;
            else         grid_d = grid_q;
            if (move_iv && (move_cnt_q < CNT_W'(MAX_MOVES))) begin
               push_s     = 1'b1;
               move_cnt_d = move_cnt_q + CNT_W'(1);
            end else if (move_iv) begin
               overflow_d = 1'b1;
            end else begin
               overflow_d = overflow_q;
            end
            if (start) begin
               state_d  = GRID_HDR;
               spi_ov_d = 1'b1;
               spi_od_d = DATA_WIDTH'(GRID_HEADER);
               busy_d   = 1'b1;
            end else begin
               spi_ov_d = 1'b0;
            end
         end
         GRID_HDR: begin
            if (xfer_s) begin
               state_d  = GRID;
               cell_d   = '0;
               spi_od_d = cell_byte(grid_q, CELL_W'(0));
            end else begin
               state_d = GRID_HDR;
            end
         end
         GRID: begin
            if (xfer_s && (cell_q == CELL_W'(CELLS - 1))) begin
               state_d  = MOVE_HDR;
               spi_od_d = DATA_WIDTH'(MOVE_HEADER);
            end else if (xfer_s) begin
               cell_d   = cell_q + CELL_W'(1);
               spi_od_d = cell_byte(grid_q, cell_q + CELL_W'(1));
            end else begin
               state_d = GRID;
            end
         end
         MOVE_HDR: begin
            if (xfer_s) begin
               state_d  = COUNT;
               spi_od_d = DATA_WIDTH'(move_cnt_q);
            end else begin
               state_d = MOVE_HDR;
            end
         end
         COUNT: begin
            if (xfer_s && (move_cnt_q == CNT_W'(0))) begin
               tail_s = 1'b1;
            end else if (xfer_s) begin
               state_d  = MOVES;
               mi_d     = '0;
               bi_d     = '0;
               spi_od_d = move_byte(buf_q[CNT_W'(0)], BIDX_W'(0));
            end else begin
               state_d = COUNT;
            end
         end
         MOVES: begin
            if (xfer_s && (bi_q == BIDX_W'(MOVE_BYTES - 1))) begin
               if (mi_q == (move_cnt_q - CNT_W'(1))) begin
                  tail_s = 1'b1;
               end else begin
                  mi_d     = mi_q + CNT_W'(1);
                  bi_d     = '0;
                  spi_od_d = move_byte(buf_q[mi_q + CNT_W'(1)], BIDX_W'(0));
               end
            end else if (xfer_s) begin
               bi_d     = bi_q + BIDX_W'(1);
               spi_od_d = move_byte(buf_q[mi_q], bi_q + BIDX_W'(1));
            end else begin
               state_d = MOVES;
            end
         end
         CKSUM: begin
            if (xfer_s) end_s = 1'b1;
            else        state_d = CKSUM;
         end
         default: begin
            state_d  = IDLE;
            spi_ov_d = 1'b0;
            busy_d   = 1'b0;
         end
      endcase

`ifdef STREAM_CHECKSUM_EN
      if (state_q == IDLE) begin
         cksum_d = '0;
      end else if (xfer_s && ((state_q == GRID) || (state_q == COUNT) || (state_q == MOVES))) begin
         cksum_d = cksum_q ^ spi_od_q;
      end else begin
         cksum_d = cksum_q;
      end
      if (tail_s) begin
         state_d  = CKSUM;
         spi_od_d = cksum_q ^ spi_od_q;
      end else begin
         state_d = state_d;
      end
`else
      if (tail_s) end_s = 1'b1;
      else        end_s = end_s;
`endif

      // Frame end frees the move buffer but keeps the grid for reuse.
      if (end_s) begin
         state_d    = IDLE;
         spi_ov_d   = 1'b0;
         spi_od_d   = '0;
         busy_d     = 1'b0;
         done_d     = 1'b1;
         move_cnt_d = '0;
         overflow_d = 1'b0;
      end else begin
         done_d = 1'b0;
      end
   end

   // Control and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         grid_q     <= '0;
         move_cnt_q <= '0;
         overflow_q <= 1'b0;
         cell_q     <= '0;
         mi_q       <= '0;
         bi_q       <= '0;
         spi_ov_q   <= 1'b0;
         spi_od_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef STREAM_CHECKSUM_EN
         cksum_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         grid_q     <= grid_d;
         move_cnt_q <= move_cnt_d;
         overflow_q <= overflow_d;
         cell_q     <= cell_d;
         mi_q       <= mi_d;
         bi_q       <= bi_d;
         spi_ov_q   <= spi_ov_d;
         spi_od_q   <= spi_od_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef STREAM_CHECKSUM_EN
         cksum_q    <= cksum_d;
`endif
      end
   end

   // Move storage needs no reset; move_cnt_q defines which entries are live.
   always_ff @(posedge clk) begin
      if (push_s) buf_q[move_cnt_q] <= move_id;
   end

   assign spi_ov   = spi_ov_q;
   assign spi_od   = spi_od_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign overflow = overflow_q;

endmodule
